up16_hazard_ctrl: RTL and testbench

UP16_HAZARD_CTRL -- requirements
Module: up16_hazard_ctrl

---
 rtl/up16_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_up16_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/up16_hazard_ctrl.sv
// Pipeline hazard and debug-halt controller for the up16 core: load-use stalls,
// branch flushes, and a halt/drain/single-step FSM with a saturating stall counter.
module up16_hazard_ctrl #(
    parameter int DSIZE = 16,
    parameter int DRAIN = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [2:0]       ID_rs1,
    input  logic [2:0]       ID_rs2,
    input  logic             ID_usesRs2,
    input  logic             EX_memRead,
    input  logic             EX_RFwriteEnab,
    input  logic [2:0]       EX_RFdest_rd,
    input  logic             ID_sel_PC,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             halted,
    output logic             step_ack,
    output logic [DSIZE-1:0] stall_count
);
    localparam int CW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED, ST_STEP} state_t;

    state_t         state;
    logic [CW-1:0]  drain_cnt;
    logic           step_flag;
    logic           ack_r;
    logic           hazard;
    logic           run_like;
    logic           stall;

    function automatic logic [DSIZE-1:0] sat_inc(input logic [DSIZE-1:0] v);
        return (&v) ? v : v + DSIZE'(1);
    endfunction

    assign hazard = EX_memRead & EX_RFwriteEnab &
                    ((EX_RFdest_rd == ID_rs1) | (ID_usesRs2 & (EX_RFdest_rd == ID_rs2)));
    assign run_like = (state == ST_RUN) || (state == ST_STEP);

    // Stall/flush decode is combinational so a load-use hazard stalls in the same cycle.
    always_comb begin
        stall      = 1'b0;
        IFID_flush = 1'b0;
        if (!Rst) begin
            if (run_like) begin
                stall      = hazard;
                IFID_flush = ~hazard & ID_sel_PC;
            end else begin
                stall      = 1'b1;
            end
        end
    end

    assign PC_stall    = stall;
    assign IFID_stall  = stall;
    assign IDEX_bubble = stall;
    assign halted      = ~Rst & (state == ST_HALTED);
    assign step_ack    = ~Rst & ack_r;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            step_flag   <= 1'b0;
            ack_r       <= 1'b0;
            stall_count <= '0;
        end else begin
            ack_r <= 1'b0;
            if (run_like && hazard)
                stall_count <= sat_inc(stall_count);
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= CW'(DRAIN);
                    end
                end
                ST_DRAIN: begin
                    // A host-initiated drain aborts as soon as the host lets go.
                    if (!step_flag && !halt_req) begin
                        state     <= ST_RUN;
                        drain_cnt <= '0;
                    end else if (drain_cnt == CW'(1)) begin
                        state     <= ST_HALTED;
                        drain_cnt <= '0;
                        if (step_flag) begin
                            ack_r     <= 1'b1;
                            step_flag <= 1'b0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                ST_HALTED: begin
                    if (step_req)
                        state <= ST_STEP;
                    else if (!halt_req)
                        state <= ST_RUN;
                end
                ST_STEP: begin
                    if (!hazard) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= CW'(DRAIN);
                        step_flag <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_up16_hazard_ctrl.sv
// Directed plus randomized bench for up16_hazard_ctrl against a cycle-level
// behavioural model of the hazard, halt, drain and single-step rules.
module tb_up16_hazard_ctrl;
    localparam int DSIZE = 4;
    localparam int DRAIN = 3;
    localparam int SAT   = (1 << DSIZE) - 1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [2:0]       ID_rs1, ID_rs2, EX_RFdest_rd;
    logic             ID_usesRs2, EX_memRead, EX_RFwriteEnab, ID_sel_PC, halt_req, step_req;
    logic             PC_stall, IFID_stall, IFID_flush, IDEX_bubble, halted, step_ack;
    logic [DSIZE-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_draining, m_halted, m_stepping, m_step_drain, m_ack;
    int m_drain_done;
    int m_count;

    up16_hazard_ctrl #(.DSIZE(DSIZE), .DRAIN(DRAIN)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_usesRs2(ID_usesRs2),
        .EX_memRead(EX_memRead), .EX_RFwriteEnab(EX_RFwriteEnab), .EX_RFdest_rd(EX_RFdest_rd),
        .ID_sel_PC(ID_sel_PC), .halt_req(halt_req), .step_req(step_req),
        .PC_stall(PC_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble), .halted(halted), .step_ack(step_ack),
        .stall_count(stall_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        return EX_memRead && EX_RFwriteEnab &&
               (EX_RFdest_rd == ID_rs1 || (ID_usesRs2 && EX_RFdest_rd == ID_rs2));
    endfunction

    task automatic model_reset();
        m_draining = 0; m_halted = 0; m_stepping = 0; m_step_drain = 0;
        m_ack = 0; m_drain_done = 0; m_count = 0;
    endtask

    task automatic model_edge();
        bit haz;
        bit active;
        haz    = model_hazard();
        active = !m_draining && !m_halted;
        if (Rst) begin
            model_reset();
            return;
        end
        m_ack = 0;
        if (active && haz) m_count = (m_count + 1 > SAT) ? SAT : m_count + 1;
        if (active && !m_stepping) begin
            if (halt_req) begin m_draining = 1; m_drain_done = 0; end
        end else if (m_stepping) begin
            if (!haz) begin
                m_stepping = 0; m_draining = 1; m_step_drain = 1; m_drain_done = 0;
            end
        end else if (m_draining) begin
            m_drain_done++;
            if (!m_step_drain && !halt_req) begin
                m_draining = 0;
            end else if (m_drain_done == DRAIN) begin
                m_draining = 0; m_halted = 1;
                if (m_step_drain) m_ack = 1;
                m_step_drain = 0;
            end
        end else if (m_halted) begin
            if (step_req) begin m_halted = 0; m_stepping = 1; end
            else if (!halt_req) m_halted = 0;
        end
    endtask

    // One clock cycle: apply inputs, compare against the model mid-cycle, advance.
    task automatic cyc(input logic [2:0] rs1, input logic [2:0] rs2, input logic us2,
                       input logic mr, input logic we, input logic [2:0] rd,
                       input logic sel, input logic hlt, input logic stp, input logic rst);
        bit haz;
        bit active;
        bit e_stall, e_flush;
        ID_rs1 = rs1; ID_rs2 = rs2; ID_usesRs2 = us2; EX_memRead = mr;
        EX_RFwriteEnab = we; EX_RFdest_rd = rd; ID_sel_PC = sel;
        halt_req = hlt; step_req = stp; Rst = rst;
        #2;
        haz     = model_hazard();
        active  = !m_draining && !m_halted;
        e_stall = !rst && (active ? haz : 1'b1);
        e_flush = !rst && active && !haz && sel;
        chk("PC_stall",    PC_stall,    e_stall);
        chk("IFID_stall",  IFID_stall,  e_stall);
        chk("IDEX_bubble", IDEX_bubble, e_stall);
        chk("IFID_flush",  IFID_flush,  e_flush);
        chk("halted",      halted,      !rst && m_halted);
        chk("step_ack",    step_ack,    !rst && m_ack);
        chk("stall_count", stall_count, m_count);
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic hl;
        model_reset();
        #1;
        // Reset
        cyc(0,0,0,0,0,0,0,0,0,1);
        cyc(0,0,0,0,0,0,0,0,0,1);
        cyc(0,0,0,0,0,0,0,0,0,0);
        // Load-use on rs1, then non-matching destination
        cyc(3,0,0,1,1,3,0,0,0,0);
        cyc(3,0,0,1,1,4,0,0,0,0);
        #2 chk("loaduse_count", stall_count, 1);
        // rs2 gating
        cyc(1,5,0,1,1,5,0,0,0,0);
        cyc(1,5,1,1,1,5,0,0,0,0);
        // Branch collision then plain branch
        cyc(3,0,0,1,1,3,1,0,0,0);
        cyc(0,0,0,0,0,0,1,0,0,0);
        // Halt: one RUN cycle with request, three drain cycles, then halted
        for (int i = 0; i < 1 + DRAIN; i++) cyc(0,0,0,0,0,0,0,1,0,0);
        cyc(0,0,0,0,0,0,0,1,0,0);
        #2 chk("halted_after_drain", halted, 1'b1);
        // Single step: pulse, STEP cycle, drain, ack on entering HALTED
        cyc(0,0,0,0,0,0,0,1,1,0);
        for (int i = 0; i < 1 + DRAIN; i++) cyc(0,0,0,0,0,0,0,1,0,0);
        #2 chk("step_ack_pulse", step_ack, 1'b1);
        cyc(0,0,0,0,0,0,0,1,0,0);
        // Release
        cyc(0,0,0,0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,1,0,0,0);
        // Abort after one drain cycle
        cyc(0,0,0,0,0,0,0,1,0,0);
        cyc(0,0,0,0,0,0,0,1,0,0);
        cyc(0,0,0,0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0,0,0,0);
        // Reset while in STEP (held there by a hazard)
        for (int i = 0; i < 2 + DRAIN; i++) cyc(0,0,0,0,0,0,0,1,0,0);
        cyc(0,0,0,0,0,0,0,1,1,0);
        cyc(2,0,0,1,1,2,0,1,0,0);
        cyc(2,0,0,1,1,2,0,1,0,1);
        cyc(0,0,0,0,0,0,0,0,0,0);
        // Saturation at 15
        for (int i = 0; i < 20; i++) cyc(6,0,0,1,1,6,0,0,0,0);
        #2 chk("saturated_count", stall_count, SAT);
        cyc(0,0,0,0,0,0,0,0,0,1);
        // Randomized traffic
        hl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) hl = ~hl;
            cyc(3'($urandom_range(3)), 3'($urandom_range(3)), 1'($urandom),
                1'($urandom), 1'($urandom_range(3) != 0), 3'($urandom_range(3)),
                1'($urandom_range(3) == 0), hl, 1'($urandom_range(3) == 0),
                1'($urandom_range(80) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
